// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator:
//   - axis_state_t : region of one raster axis (ACTIVE -> FP -> SYNC -> BP)
//   - CNT_W        : width of the position counters
//   - MAX_TOTAL    : largest axis total the counters can represent
//   - DEF_*        : 640x480@60 timing (800 x 525 total)
//   - axis_total() : total length of an axis from its four region lengths
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FP     = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BP     = 2'd3
    } axis_state_t;

    function automatic int axis_total(input int len_active, input int len_fp,
                                      input int len_sync, input int len_bp);
        return len_active + len_fp + len_sync + len_bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a position counter plus the region state machine that
// tracks which region (ACTIVE/FP/SYNC/BP) the current count lies in.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   adv       : advance by one position this cycle
//   cnt       : current position, 0..TOTAL-1
//   state     : region of the current position
//   wrap      : high in the advancing cycle where cnt is TOTAL-1
// ---------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int LEN_ACTIVE = DEF_H_ACTIVE,
    parameter int LEN_FP     = DEF_H_FP,
    parameter int LEN_SYNC   = DEF_H_SYNC,
    parameter int LEN_BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output axis_state_t      state,
    output logic             wrap
);

    localparam int TOTAL = axis_total(LEN_ACTIVE, LEN_FP, LEN_SYNC, LEN_BP);

    generate
        if (TOTAL > MAX_TOTAL) begin : g_total_too_big
            $error("vga_axis_counter: axis total exceeds counter range");
        end
        if (LEN_ACTIVE < 1 || LEN_FP < 1 || LEN_SYNC < 1 || LEN_BP < 1) begin : g_empty_region
            $error("vga_axis_counter: every region needs at least one position");
        end
    endgenerate

    // Last position of each region; the state moves on when it is consumed.
    localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(LEN_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP     = CNT_W'(LEN_ACTIVE + LEN_FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(LEN_ACTIVE + LEN_FP + LEN_SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_BP     = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    axis_state_t      state_q, state_d;

    assign wrap = adv && (cnt_q == LAST_BP);

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (adv) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            case (state_q)
                ST_ACTIVE: if (cnt_q == LAST_ACTIVE) state_d = ST_FP;
                ST_FP:     if (cnt_q == LAST_FP)     state_d = ST_SYNC;
                ST_SYNC:   if (cnt_q == LAST_SYNC)   state_d = ST_BP;
                ST_BP:     if (wrap)                 state_d = ST_ACTIVE;
                default:                             state_d = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= ST_ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign cnt   = cnt_q;
    assign state = state_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Free-running VGA raster timing generator. Advances one pixel per clk with
// ce=1; all outputs are registered so the sync pads never glitch.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   ce           : pixel-clock enable
//   hsync, vsync : sync outputs, at level SYNC_POL while asserted
//   de           : display enable (both axes in ACTIVE)
//   x, y         : position of the pixel consumed by the last enabled cycle
//   line_start   : one-clk strobe after consuming x==0
//   frame_start  : one-clk strobe after consuming x==0, y==0
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    axis_state_t      h_state, v_state;
    logic             h_wrap, v_wrap;

    vga_axis_counter #(
        .LEN_ACTIVE(H_ACTIVE), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP)
    ) u_h_axis (
        .clk(clk), .rst(rst), .adv(ce),
        .cnt(h_cnt), .state(h_state), .wrap(h_wrap)
    );

    // The vertical axis steps once per line: h_wrap already includes ce.
    vga_axis_counter #(
        .LEN_ACTIVE(V_ACTIVE), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP)
    ) u_v_axis (
        .clk(clk), .rst(rst), .adv(h_wrap),
        .cnt(v_cnt), .state(v_state), .wrap(v_wrap)
    );

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    // High while the counters sit at (0,0): set by reset and by the cycle
    // in which both axes wrap together.
    logic             origin_q, origin_d;

    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        origin_d      = origin_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (ce) begin
            hsync_d       = (h_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = (v_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            de_d          = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
            x_d           = h_cnt;
            y_d           = v_cnt;
            line_start_d  = (h_cnt == '0);
            frame_start_d = origin_q;
            origin_d      = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            origin_q      <= 1'b1;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            origin_q      <= origin_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Instance A: default 640x480 timing, active-low sync.
// Instance B: 4/1/2/1 on both axes (8x8 total), active-high sync, driven
//             with a random ~30% ce and compared against a position model.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, ce_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       rst_b, ce_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;

    int tests = 0;
    int fails = 0;

    vga_timing_gen u_dut_a (
        .clk(clk), .rst(rst_a), .ce(ce_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .ce(ce_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    typedef struct {
        int         k;      // enabled-cycle number after reset (1 = first)
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] pk(input logic hs, input logic vs, input logic de,
                                       input logic ls, input logic fs,
                                       input logic [9:0] x, input logic [9:0] y);
        return {hs, vs, de, ls, fs, x, y};
    endfunction

    task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d, want hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d",
                     name, act[24], act[23], act[22], act[21], act[20], act[19:10], act[9:0],
                     exp[24], exp[23], exp[22], exp[21], exp[20], exp[19:10], exp[9:0]);
        end else begin
            $display("ok   %s: hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d",
                     name, act[24], act[23], act[22], act[21], act[20], act[19:10], act[9:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Region index for the 4/1/2/1 axis: 0 ACTIVE, 1 FP, 2 SYNC, 3 BP.
    function automatic int region(input int c);
        if (c < 4) return 0;
        if (c < 5) return 1;
        if (c < 7) return 2;
        return 3;
    endfunction

    // Expected outputs of instance B after consuming raster position p.
    function automatic logic [24:0] small_exp(input int p, input bit strobes);
        int   h;
        int   v;
        logic hs, vs, de, ls, fs;
        h  = p % 8;
        v  = (p / 8) % 8;
        hs = (region(h) == 2);
        vs = (region(v) == 2);
        de = (h < 4) && (v < 4);
        ls = strobes && (h == 0);
        fs = strobes && (h == 0) && (v == 0);
        return pk(hs, vs, de, ls, fs, 10'(h), 10'(v));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs_low, de_hi, ls_cnt, first_low, last_low, ls_prev, ls_period;
        int en, cyc, last_fs;
        bit prev_ce;

        //            k     x      y     de hs vs ls fs
        vecs[0]  = '{1,    10'd0,   10'd0, 1, 1, 1, 1, 1};
        vecs[1]  = '{2,    10'd1,   10'd0, 1, 1, 1, 0, 0};
        vecs[2]  = '{640,  10'd639, 10'd0, 1, 1, 1, 0, 0};
        vecs[3]  = '{641,  10'd640, 10'd0, 0, 1, 1, 0, 0};
        vecs[4]  = '{656,  10'd655, 10'd0, 0, 1, 1, 0, 0};
        vecs[5]  = '{657,  10'd656, 10'd0, 0, 0, 1, 0, 0};
        vecs[6]  = '{752,  10'd751, 10'd0, 0, 0, 1, 0, 0};
        vecs[7]  = '{753,  10'd752, 10'd0, 0, 1, 1, 0, 0};
        vecs[8]  = '{800,  10'd799, 10'd0, 0, 1, 1, 0, 0};
        vecs[9]  = '{801,  10'd0,   10'd1, 1, 1, 1, 1, 0};
        vecs[10] = '{1601, 10'd0,   10'd2, 1, 1, 1, 1, 0};

        rst_a = 1'b1; ce_a = 1'b0;
        rst_b = 1'b1; ce_b = 1'b0;
        repeat (3) step();
        check("A reset state", pk(hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a), pk(1, 1, 0, 0, 0, 0, 0));
        check("B reset state", pk(hs_b, vs_b, de_b, ls_b, fs_b, x_b, y_b), pk(0, 0, 0, 0, 0, 0, 0));

        // ---- Instance A: continuous ce, table of hand-computed positions ----
        rst_a = 1'b0;
        ce_a  = 1'b1;
        n = 0;
        for (int i = 0; i < 11; i++) begin
            while (n < vecs[i].k) begin
                step();
                n++;
            end
            check($sformatf("A vec%0d k=%0d", i, vecs[i].k),
                  pk(hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a),
                  pk(vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].ls, vecs[i].fs,
                     vecs[i].x, vecs[i].y));
        end

        // ---- Instance A: statistics over 800 enabled cycles ----
        hs_low = 0; de_hi = 0; ls_cnt = 0; first_low = -1; last_low = -1;
        ls_prev = n; ls_period = 0;
        repeat (800) begin
            step();
            n++;
            if (!hs_a) begin
                if (first_low < 0) first_low = int'(x_a);
                last_low = int'(x_a);
                hs_low++;
            end
            if (de_a) de_hi++;
            if (ls_a) begin
                ls_cnt++;
                ls_period = n - ls_prev;
                ls_prev = n;
            end
        end
        check_int("A hsync low cycles per line", hs_low, 96);
        check_int("A hsync first low x", first_low, 656);
        check_int("A hsync last low x", last_low, 751);
        check_int("A de high cycles per line", de_hi, 640);
        check_int("A line_start count per line", ls_cnt, 1);
        check_int("A line_start period", ls_period, 800);

        // ---- Instance A: asynchronous reset at (700,3) while hsync is low ----
        while (n < 3101) begin
            step();
            n++;
        end
        check("A at x=700 y=3", pk(hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a), pk(0, 1, 0, 0, 0, 700, 3));
        #2 rst_a = 1'b1;
        #1;
        check("A async reset mid-cycle", pk(hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a), pk(1, 1, 0, 0, 0, 0, 0));
        step();
        step();
        rst_a = 1'b0;
        step();
        check("A first ce after reset", pk(hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a), pk(1, 1, 1, 1, 1, 0, 0));
        ce_a = 1'b0;
        step();
        check("A ce=0 hold, strobes low", pk(hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a), pk(1, 1, 1, 0, 0, 0, 0));
        ce_a = 1'b1;
        step();
        check("A resume after hold", pk(hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a), pk(1, 1, 1, 0, 0, 1, 0));
        ce_a = 1'b0;

        // ---- Instance B: random ~30% ce against the position model ----
        rst_b = 1'b0;
        en = 0; cyc = 0; last_fs = -1;
        while (en < 140 && cyc < 3000) begin
            ce_b = ($urandom_range(0, 99) < 30);
            prev_ce = ce_b;
            step();
            cyc++;
            if (prev_ce) begin
                check($sformatf("B enabled #%0d", en),
                      pk(hs_b, vs_b, de_b, ls_b, fs_b, x_b, y_b), small_exp(en, 1'b1));
                if (fs_b) begin
                    if (last_fs >= 0) check_int("B frame_start period", en - last_fs, 64);
                    last_fs = en;
                end
                en++;
            end else begin
                check($sformatf("B idle cycle %0d", cyc),
                      pk(hs_b, vs_b, de_b, ls_b, fs_b, x_b, y_b),
                      (en == 0) ? pk(0, 0, 0, 0, 0, 0, 0) : small_exp(en - 1, 1'b0));
            end
        end
        ce_b = 1'b0;
        check_int("B enabled cycles completed", en, 140);
        check_int("B last frame_start index", last_fs, 128);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator for the MiscStuff design slot inside `chip_top`. It produces `hsync`/`vsync` on their bidirectional pads (bit 33 and bit 29), and provides pixel coordinates and blanking information to the pixel-generation logic. The block advances one pixel per enabled clock and defaults to 640x480@60 (800x525 total). All outputs are registered, so sync edges are glitch-free at the pads.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync pulse width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync pulse width
- `V_BP`, 33: vertical back porch
- `SYNC_POL`, 0: asserted sync level (0 = active-low)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `ce`  in  1  pixel-clock enable; the raster advances only when it is 1
- `hsync`  out  1  horizontal sync, at level `SYNC_POL` when asserted
- `vsync`  out  1  vertical sync, at level `SYNC_POL` when asserted
- `de`  out  1  display enable: high in the active area
- `x`  out  10  horizontal position, 0..H_total-1
- `y`  out  10  vertical position, 0..V_total-1
- `line_start`  out  1  one-`clk` strobe at x==0
- `frame_start`  out  1  one-`clk` strobe at x==0 and y==0

## Operation
- Totals: H_total = sum of the H_* parameters (800); V_total = sum of the V_* parameters (525). Counters are 10 bits wide. Elaboration fails if either total exceeds 1024.
- Horizontal counter `hc` increments on `ce`. At H_total-1 it wraps to 0 and issues a line tick.
- Vertical counter `vc` increments on a line tick. At V_total-1 it wraps to 0.
- Each axis has a state machine with states ACTIVE → FP → SYNC → BP → ACTIVE.
  - State transitions occur on the enabled cycle in which the count reaches that region's last index.
  - Horizontal region boundaries are 0..639 ACTIVE, 640..655 FP, 656..751 SYNC, 752..799 BP. Vertical boundaries follow the same pattern.
  - The vertical state machine advances only on line ticks.
- Output decode is registered and updated only when `ce`=1:
  - `hsync` = SYNC_POL when the horizontal state is SYNC, else ~SYNC_POL. `vsync` is decoded the same way.
  - `de` = (h state ACTIVE) AND (v state ACTIVE).
  - `x` = hc and `y` = vc, taken from the pre-increment values.
- `line_start` and `frame_start` are high for exactly one `clk` cycle: the cycle after the enabled cycle in which hc==0 (and, for `frame_start`, vc==0). They are 0 otherwise, including on cycles where `ce`=0.
- When `ce`=0, all counters, states and level outputs hold their values.
- Reset clears all state on `rst`, asynchronously:
  - hc=vc=0; both state machines go to ACTIVE.
  - hsync=vsync=~SYNC_POL, de=0, x=y=0, line_start=frame_start=0.
  - Reset asserted mid-frame aborts the frame immediately. After release, the raster restarts at (0,0).

## Timing
- Latency is one enabled cycle. The outputs for position (h,v) appear after the `ce` edge that consumed (h,v).
- The first `ce` after reset release gives de=1, x=0, y=0, line_start=1, frame_start=1.
- hsync asserts at output x=656 and deasserts at x=752, giving 96 enabled cycles. vsync asserts at y=490, aligned with x=0 of that line, and stays asserted for 2 lines.
- One frame is 420000 enabled cycles. `frame_start` repeats exactly every 420000 `ce` pulses.
- The line wrap and frame wrap coincide on the same enabled cycle at (799,524). Both counters wrap together, and both strobes fire on the following output cycle.

## Structure
- Package `vga_timing_pkg` holds:
  - the axis state enum (ACTIVE, FP, SYNC, BP);
  - the 640x480@60 default constants;
  - a total-width helper function.
- Sub-module `vga_axis_counter` is instantiated twice (horizontal and vertical). It provides the count, the region state, a wrap tick and an advance input, and takes the ACTIVE/FP/SYNC/BP lengths as parameters.
- The top level holds only the output registers, the strobes and the polarity logic.

## Test plan
- Reset, then continuous `ce` → first output cycle has de=1, x=0, y=0, frame_start=1; hsync=vsync=1 (active-low default).
- Count enabled cycles across one line → hsync is low for exactly 96 cycles starting at x=656; de is low for x≥640; line_start period is 800.
- Run one full frame → vsync is low for exactly 1600 enabled cycles starting at (0,490); frame_start period is 420000; y never exceeds 524.
- Drive `ce` with a random ~30% duty cycle → the output sequence per enabled cycle is identical to the continuous-`ce` run; strobes are never wider than one `clk`.
- Assert `rst` at (700,300) while hsync is low → hsync/vsync return to 1 and de goes to 0 immediately. After release, the first `ce` gives x=0, y=0, frame_start=1.
- Set `SYNC_POL`=1 and small parameters (4/1/2/1 on both axes) → sync pulses are active-high; H_total=V_total=8, so the frame period is 64 enabled cycles.
